// File: rtl/vector_frame_pkg.sv
// Shared types and constants for the vector display frame-source arbiter.
package vector_frame_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } frame_state_t;

    localparam int VEC_WORD_W = 18;

    // Pen up with the beam parked at the origin.
    localparam logic [VEC_WORD_W-1:0] VF_BLANK_WORD = '0;

    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/vector_frame_arbiter_pick.sv
// Combinational target picker: priority (highest request) or circular rotation.
module frame_arbiter_pick #(
    parameter  int NSRC        = 4,
    parameter  int DEFAULT_SRC = 0,
    localparam int SW          = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [SW-1:0]   i_sel,
    input  logic            i_mode,
    input  logic            i_hold_done,
    output logic [SW-1:0]   o_target
);

    localparam logic [SW-1:0] DEF_SEL = SW'(DEFAULT_SRC);

    logic [SW-1:0] w_prio;
    logic [SW-1:0] w_rot;

    always_comb begin
        w_prio = DEF_SEL;
        for (int i = 0; i < NSRC; i++) begin
            if (i_req[i[SW-1:0]]) w_prio = i[SW-1:0];
        end
    end

    // Walk downwards so the nearest set bit after i_sel wins; i_sel itself is the last resort.
    always_comb begin
        int idx;
        idx   = 0;
        w_rot = DEF_SEL;
        if (i_req[i_sel]) w_rot = i_sel;
        for (int k = NSRC - 1; k >= 1; k--) begin
            idx = (int'(i_sel) + k) % NSRC;
            if (i_req[idx[SW-1:0]]) w_rot = idx[SW-1:0];
        end
    end

    always_comb begin
        o_target = w_prio;
        if (i_mode) o_target = i_hold_done ? w_rot : i_sel;
    end

endmodule

// File: rtl/vector_frame_arbiter.sv
// Frame-synchronous source selector for the vector display, with blanking frames on every switch.
module vector_frame_arbiter
    import vector_frame_pkg::*;
#(
    parameter int                    NSRC           = 4,
    parameter int                    ADDRESSWIDTH   = 16,
    parameter int                    DATAWIDTH      = 18,
    parameter int                    DEFAULT_SRC    = 0,
    parameter int                    BLANK_FRAMES   = 1,
    parameter int                    HOLD_FRAMES    = 60,
    parameter logic [DATAWIDTH-1:0]  BLANK_WORD     = DATAWIDTH'(VF_BLANK_WORD),
    parameter int                    TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NSRC-1:0]             i_req,
    input  logic                        i_mode,
    input  logic                        i_frame_done,
    input  logic [ADDRESSWIDTH-1:0]     i_adr_in,
    input  logic [NSRC*DATAWIDTH-1:0]   i_data_src,
    output logic [ADDRESSWIDTH-1:0]     o_adr_out,
    output logic [DATAWIDTH-1:0]        o_data_out,
    output logic [$clog2(NSRC)-1:0]     o_sel,
    output logic                        o_blanking,
    output logic                        o_switched,
    output logic                        o_timeout
);

    localparam int SW = $clog2(NSRC);
    localparam int HW = cnt_width(HOLD_FRAMES);
    localparam int BW = cnt_width(BLANK_FRAMES);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] DEF_SEL    = SW'(DEFAULT_SRC);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES - 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_FRAMES);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES - 1);

    frame_state_t  r_state, w_state_next;
    logic [SW-1:0] r_sel, w_sel_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic [BW-1:0] r_blank, w_blank_next;
    logic [TW-1:0] r_to, w_to_next;
    logic          r_mode;
    logic          r_switched, w_switched_next;

    logic          w_timeout;
    logic          w_bnd;
    logic          w_hold_done;
    logic [SW-1:0] w_target;

    logic [DATAWIDTH-1:0] w_src [NSRC];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_src[gi] = i_data_src[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    assign w_timeout   = (r_to == TO_MAX);
    assign w_bnd       = i_frame_done | w_timeout;
    assign w_hold_done = (r_hold == HOLD_MAX);

    frame_arbiter_pick #(
        .NSRC        (NSRC),
        .DEFAULT_SRC (DEFAULT_SRC)
    ) u_pick (
        .i_req       (i_req),
        .i_sel       (r_sel),
        .i_mode      (r_mode),
        .i_hold_done (w_hold_done),
        .o_target    (w_target)
    );

    always_comb begin
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_hold_next     = r_hold;
        w_blank_next    = r_blank;
        w_switched_next = 1'b0;
        w_to_next       = w_bnd ? '0 : r_to + TW'(1);

        case (r_state)
            SHOW: begin
                if (w_bnd) begin
                    if (w_target != r_sel) begin
                        w_sel_next      = w_target;
                        w_switched_next = 1'b1;
                        w_hold_next     = '0;
                        if (BLANK_FRAMES > 0) begin
                            w_state_next = BLANK;
                            w_blank_next = BLANK_INIT;
                        end
                    end else if (r_mode && w_hold_done) begin
                        w_hold_next = '0;
                    end else if (!w_hold_done) begin
                        w_hold_next = r_hold + HW'(1);
                    end
                end
            end
            BLANK: begin
                if (w_bnd) begin
                    w_blank_next = r_blank - BW'(1);
                    if (r_blank == BW'(1)) w_state_next = SHOW;
                end
            end
            default: w_state_next = SHOW;
        endcase

        // A freshly seen mode restarts the hold period.
        if (i_mode != r_mode) w_hold_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SHOW;
            r_sel      <= DEF_SEL;
            r_hold     <= '0;
            r_blank    <= '0;
            r_to       <= '0;
            r_mode     <= 1'b0;
            r_switched <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_hold     <= w_hold_next;
            r_blank    <= w_blank_next;
            r_to       <= w_to_next;
            r_mode     <= i_mode;
            r_switched <= w_switched_next;
        end
    end

    assign o_adr_out  = i_adr_in;
    assign o_data_out = (r_state == BLANK) ? BLANK_WORD : w_src[r_sel];
    assign o_sel      = r_sel;
    assign o_blanking = (r_state == BLANK);
    assign o_switched = r_switched;
    assign o_timeout  = w_timeout;

endmodule
